// File: rtl/spike_window_classifier.sv
// Windowed spike counter + sequential argmax over N_NEURONS output neurons.
// Optional SPIKE_WIN_NEG_SUB_EN: inhibitory strobes decrement counters (floored at 0).

module spike_win_lane #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             pos,
    input  logic             neg,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef SPIKE_WIN_NEG_SUB_EN
    // Simultaneous pos+neg cancel out.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (pos && !neg && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            else if (neg && !pos && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end
`else
    logic unused_neg;
    assign unused_neg = neg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && pos && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif
endmodule

module spike_window_classifier #(
    parameter int N_NEURONS = 4,
    parameter int CNT_W     = 8,
    parameter int WIN_W     = 16,
    parameter int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIN_W-1:0]     window_len,
    input  logic [N_NEURONS-1:0] pos_spk,
    input  logic [N_NEURONS-1:0] neg_spk,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [IDX_W-1:0]     winner_idx,
    output logic [CNT_W-1:0]     winner_count,
    output logic                 tie,
    output logic                 no_spike
);
    typedef enum logic [1:0] {IDLE, COUNT, COMPARE, HOLD} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_t                         state, state_nxt;
    logic [WIN_W-1:0]               win_cnt;
    logic [IDX_W-1:0]               scan_idx;
    logic [N_NEURONS-1:0][CNT_W-1:0] cnt;
    logic                           start_ok;
    logic [CNT_W-1:0]               cand;
    logic                           first, gt, eq;
    logic [CNT_W-1:0]               new_max;

    assign start_ok = (state == IDLE) && start;

    genvar g;
    generate
        for (g = 0; g < N_NEURONS; g++) begin : g_lane
            spike_win_lane #(.CNT_W(CNT_W)) u_lane (
                .clk (clk),
                .rst (rst),
                .clr (start_ok),
                .en  (state == COUNT),
                .pos (pos_spk[g]),
                .neg (neg_spk[g]),
                .cnt (cnt[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (window_len == '0) ? COMPARE : COUNT;
            COUNT:   if (win_cnt == WIN_W'(1)) state_nxt = COMPARE;
            COMPARE: if (scan_idx == LAST_IDX) state_nxt = HOLD;
            HOLD:    if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state == COUNT) || (state == COMPARE);
        result_valid = (state == HOLD);
    end

    // Running max: only a strictly greater count moves the winner, so the lowest index wins ties.
    assign cand    = cnt[scan_idx];
    assign first   = (scan_idx == '0);
    assign gt      = cand > winner_count;
    assign eq      = cand == winner_count;
    assign new_max = (first || gt) ? cand : winner_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt      <= '0;
            scan_idx     <= '0;
            winner_idx   <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
            no_spike     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        win_cnt  <= window_len;
                        scan_idx <= '0;
                    end
                end
                COUNT: win_cnt <= win_cnt - 1'b1;
                COMPARE: begin
                    scan_idx <= scan_idx + 1'b1;
                    if (first) begin
                        winner_count <= cand;
                        winner_idx   <= '0;
                        tie          <= 1'b0;
                    end else if (gt) begin
                        winner_count <= cand;
                        winner_idx   <= scan_idx;
                        tie          <= 1'b0;
                    end else if (eq) begin
                        tie <= 1'b1;
                    end
                    if (scan_idx == LAST_IDX)
                        no_spike <= (new_max == '0);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_window_classifier.sv
// Directed bench for spike_window_classifier; scoreboard queue checked by a monitor on result_valid rise.
// Expected feature-test count follows SPIKE_WIN_NEG_SUB_EN.

module tb_spike_window_classifier;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] window_len = '0;
    logic [N-1:0] pos_spk = '0;
    logic [N-1:0] neg_spk = '0;
    logic        busy, result_valid;
    logic        result_ready = 1'b0;
    logic [1:0]  winner_idx;
    logic [7:0]  winner_count;
    logic        tie, no_spike;

    spike_window_classifier #(.N_NEURONS(N), .CNT_W(8), .WIN_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .window_len   (window_len),
        .pos_spk      (pos_spk),
        .neg_spk      (neg_spk),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .winner_idx   (winner_idx),
        .winner_count (winner_count),
        .tie          (tie),
        .no_spike     (no_spike)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int cnt;
        int tie;
        int ns;
        int rise;
    } exp_t;

    exp_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int po[4], ne[4], bo[4];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every result against the oldest expectation.
    initial begin
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (result_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("winner_idx", winner_idx, e.idx);
                    chk("winner_count", winner_count, e.cnt);
                    chk("tie", tie, e.tie);
                    chk("no_spike", no_spike, e.ns);
                    chk("latency_edge", cyc, e.rise);
                end
            end
            prev_v = result_valid;
        end
    end

    task automatic wait_valid(input int budget);
        int i = 0;
        while (!result_valid && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("valid_timeout", result_valid, 1);
    endtask

    // Window stimulus: per neuron, po pos-only cycles, then ne neg-only, then bo pos+neg.
    task automatic run_win(input int w, input int ei, input int ec, input int et, input int en,
                           input bit hold);
        exp_t e;
        e.idx = ei; e.cnt = ec; e.tie = et; e.ns = en; e.rise = cyc + 1 + w + N;
        exp_q.push_back(e);
        start = 1'b1;
        window_len = 16'(w);
        pos_spk = '1;                    // on the start edge: must be ignored
        neg_spk = '0;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < w; j++) begin
            for (int i = 0; i < N; i++) begin
                pos_spk[i] = (j < po[i]) ||
                             (j >= po[i] + ne[i] && j < po[i] + ne[i] + bo[i]);
                neg_spk[i] = (j >= po[i] && j < po[i] + ne[i] + bo[i]);
            end
            @(negedge clk);
        end
        pos_spk = '1;                    // during COMPARE: must be ignored
        neg_spk = '0;
        @(negedge clk);
        @(negedge clk);
        pos_spk = '0;
        wait_valid(20);
        if (hold) begin
            for (int c = 0; c < 5; c++) begin
                chk("hold_valid", result_valid, 1);
                chk("hold_busy", busy, 0);
                chk("hold_idx", winner_idx, ei);
                chk("hold_count", winner_count, ec);
                start = (c == 2);
                @(negedge clk);
            end
            start = 1'b1;
            result_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            result_ready = 1'b0;
            chk("retire_valid", result_valid, 0);
            chk("retire_busy", busy, 0);
            @(negedge clk);
            chk("start_with_ready_ignored", busy, 0);
            chk("idx_kept_after_retire", winner_idx, ei);
        end else begin
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
            chk("retire_valid", result_valid, 0);
            chk("retire_busy", busy, 0);
        end
    endtask

    task automatic clr_pat();
        po = '{0, 0, 0, 0};
        ne = '{0, 0, 0, 0};
        bo = '{0, 0, 0, 0};
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("idle_busy", busy, 0);
            chk("idle_valid", result_valid, 0);
            @(negedge clk);
        end
        chk("rst_idx", winner_idx, 0);
        chk("rst_count", winner_count, 0);
        chk("rst_tie", tie, 0);
        chk("rst_no_spike", no_spike, 0);

        // Basic winner
        clr_pat(); po[2] = 7; po[0] = 3;
        run_win(20, 2, 7, 0, 0, 0);
        // Tie: lowest index wins
        clr_pat(); po[1] = 5; po[3] = 5;
        run_win(10, 1, 5, 1, 0, 0);
        // No spikes
        clr_pat();
        run_win(10, 0, 0, 1, 1, 0);
        // Saturation
        clr_pat(); po[0] = 300;
        run_win(300, 0, 255, 0, 0, 0);
        // Zero-length window
        clr_pat();
        run_win(0, 0, 0, 1, 1, 0);
        // Inhibitory strobes
        clr_pat(); po[1] = 6; ne[1] = 4; bo[1] = 1;
`ifdef SPIKE_WIN_NEG_SUB_EN
        run_win(12, 1, 2, 0, 0, 0);
`else
        run_win(12, 1, 7, 0, 0, 0);
`endif
        // Back-pressure with stray start
        clr_pat(); po[3] = 2;
        run_win(5, 3, 2, 0, 0, 1);

        // Reset mid-COUNT aborts without a result
        start = 1'b1;
        window_len = 16'd50;
        @(negedge clk);
        start = 1'b0;
        pos_spk = 4'b0010;
        repeat (10) @(negedge clk);
        chk("count_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pos_spk = '0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", result_valid, 0);
        chk("abort_idx", winner_idx, 0);
        chk("abort_count", winner_count, 0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (result_valid || busy) chk("abort_stays_idle", 1, 0);
        end
        chk("abort_valid_end", result_valid, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spike_window_classifier.md
Name: spike_window_classifier

Overview:
- Downstream stage of the output neuron layer.
- Counts per-neuron output spikes over a programmable window of clock cycles. Then scans the counts and reports the index of the winning (most-spiking) neuron through a valid/ready handshake.
- Feeds the readout/scoreboard logic. One classification per start request.

Parameters:
- N_NEURONS, 4, number of output neurons observed (≥2).
- CNT_W, 8, width of each per-neuron spike counter.
- WIN_W, 16, width of the window length input.
- IDX_W, $clog2(N_NEURONS), width of the winner index.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new classification window; accepted only in IDLE.
- window_len  input  WIN_W  window length W in clock cycles; sampled on the start-accepting edge.
- pos_spk  input  N_NEURONS  one-cycle excitatory spike strobes, one bit per neuron.
- neg_spk  input  N_NEURONS  one-cycle inhibitory spike strobes, one bit per neuron.
- busy  output  1  high in COUNT and COMPARE.
- result_valid  output  1  result available; high in HOLD.
- result_ready  input  1  consumer accepts the result.
- winner_idx  output  IDX_W  index of the neuron with the highest count.
- winner_count  output  CNT_W  count of the winning neuron.
- tie  output  1  another neuron equals the maximum count.
- no_spike  output  1  all counts are zero.

Behaviour:
- Reset: synchronous, active-high. Forces state IDLE and clears all counters. busy, result_valid, winner_idx, winner_count, tie and no_spike all go to 0. Reset mid-window or mid-compare aborts with no result.
- States: IDLE, COUNT, COMPARE, HOLD.
- IDLE:
  - On an edge with start=1: clear all counters, load the window counter with window_len, go to COUNT.
  - If window_len=0, go directly to COMPARE with all counters zero.
- COUNT:
  - Samples pos_spk/neg_spk on each of exactly W edges (edges k+1..k+W after the start edge k).
  - The window counter decrements each edge; at the W-th edge go to COMPARE. Spikes on that edge are still counted.
- Counting:
  - Each pos_spk bit high increments its counter by 1.
  - Counters saturate at 2^CNT_W-1; no wrap.
  - neg_spk handling depends on the optional feature below.
  - Spikes outside COUNT are ignored.
- COMPARE:
  - Sequential scan, one neuron per edge, index 0 to N_NEURONS-1. Takes N edges.
  - A running max updates only on a strictly greater count, so the lowest index wins ties.
  - tie is set if any later index equals the running max. tie is cleared when a new strict max is found.
  - After the last index, go to HOLD.
- HOLD:
  - result_valid=1. winner_idx, winner_count, tie and no_spike are stable.
  - no_spike=1 iff winner_count=0. In that case winner_idx=0, tie=1.
  - On an edge with result_ready=1, go to IDLE and drop result_valid. Outputs keep their values until the next COMPARE begins.
- Latency: result_valid rises on edge k+W+N_NEURONS, where k is the start edge.
- start while not IDLE is ignored; it is not queued.
- start and result_ready on the same edge in HOLD: the result is retired and start is ignored. A new start is needed in IDLE.
- busy=1 exactly in COUNT and COMPARE.

Optional Feature:
- Macro: SPIKE_WIN_NEG_SUB_EN.
- Defined:
  - A neg_spk bit decrements its counter by 1, floored at 0.
  - pos and neg on the same neuron in the same edge leave the counter unchanged.
- Undefined: neg_spk is ignored entirely and only pos_spk is counted.

Test Plan:
All scenarios use N_NEURONS=4 and CNT_W=8.
- Reset then idle: start=0 for 10 cycles -> busy=0, result_valid=0, all result outputs 0.
- Basic winner: W=20; neuron2 spikes 7 times, neuron0 spikes 3 times, others 0 -> result_valid on edge k+24; winner_idx=2, winner_count=7, tie=0, no_spike=0.
- Tie and empty:
  - W=10 with neurons 1 and 3 spiking 5 times each -> winner_idx=1, count=5, tie=1.
  - W=10 with no spikes -> winner_idx=0, count=0, no_spike=1, tie=1.
- Saturation and window_len=0:
  - pos_spk[0] held high for W=300 -> count=255.
  - W=0 -> result_valid on edge k+4 with no_spike=1.
- Handshake and reset:
  - result_ready held low for 5 cycles -> outputs stable, start ignored. Raise ready -> IDLE next edge.
  - rst pulsed mid-COUNT -> IDLE, no result_valid.
- Feature:
  - With SPIKE_WIN_NEG_SUB_EN, neuron1 gets 6 pos, 4 neg and 1 simultaneous pos+neg -> count=2.
  - Without the macro, the same stimulus -> count=7.
